// File: rtl/pic_core_n.sv
// Parametrised programmable interrupt controller core: synchronised request lines,
// fixed/rotating priority, nested in-service tracking and a two-strobe acknowledge.
module pic_core_n #(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned VEC_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               rd_en,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               inta,
    output logic               int_o,
    output logic [VEC_W-1:0]   vec_o,
    output logic               vec_valid
);

    localparam int unsigned     ID_W    = $clog2(NUM_IRQ);
    localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_IRQ - 1);
    localparam logic [ID_W:0]   NumIrqW = (ID_W + 1)'(NUM_IRQ);

    typedef enum logic {StIdle, StAck2} state_e;

    logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, mask_q, mask_d, trig_q, trig_d;
    logic [VEC_W-1:0]   base_q, base_d, vec_q, vec_d;
    logic               rot_q, rot_d, aeoi_q, aeoi_d;
    logic [ID_W-1:0]    last_q, last_d, id_q, id_d;
    state_e             state_q, state_d;
    logic               spur_q, spur_d, int_q, int_d, vec_valid_q, vec_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic [NUM_IRQ-1:0] pend, rise, isr_set, isr_clr;
    logic [ID_W-1:0]    start, pend_rank, isr_rank, win_id, isr_top_id, eoi_id;
    logic               pend_any, isr_any, win_ok, ack1, ack2, eoi_id_ok;
    logic               unused_wr;

    assign unused_wr = ^wr_data;

    // Rotate so that bit 0 of the result is the highest-priority channel.
    function automatic logic [NUM_IRQ-1:0] rotate_vec(input logic [NUM_IRQ-1:0] v,
                                                      input logic [ID_W-1:0]    s);
        logic [2*NUM_IRQ-1:0] dbl;
        dbl = {v, v};
        return dbl[s +: NUM_IRQ];
    endfunction

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (v[j]) r = ID_W'(j);
        end
        return r;
    endfunction

    function automatic logic [ID_W-1:0] rank_to_id(input logic [ID_W-1:0] r,
                                                   input logic [ID_W-1:0] s);
        logic [ID_W:0] sum;
        sum = {1'b0, r} + {1'b0, s};
        if (sum >= NumIrqW) sum = sum - NumIrqW;
        return sum[ID_W-1:0];
    endfunction

    always_comb begin
        start      = (rot_q && last_q != LastId) ? last_q + 1'b1 : '0;
        pend       = irr_q & ~mask_q;
        pend_any   = |pend;
        isr_any    = |isr_q;
        pend_rank  = lowest_set(rotate_vec(pend, start));
        isr_rank   = lowest_set(rotate_vec(isr_q, start));
        win_id     = rank_to_id(pend_rank, start);
        isr_top_id = rank_to_id(isr_rank, start);
        win_ok     = pend_any && (!isr_any || pend_rank < isr_rank);
        rise       = sync2_q & ~prev_q;
        ack1       = (state_q == StIdle) && inta;
        ack2       = (state_q == StAck2) && inta;
        eoi_id     = wr_data[ID_W-1:0];
        eoi_id_ok  = {1'b0, eoi_id} < NumIrqW;
    end

    always_comb begin
        sync1_d     = irq_lines;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        mask_d      = mask_q;
        trig_d      = trig_q;
        base_d      = base_q;
        rot_d       = rot_q;
        aeoi_d      = aeoi_q;
        last_d      = last_q;
        state_d     = state_q;
        id_d        = id_q;
        spur_d      = spur_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        rd_data_d   = rd_data_q;
        isr_set     = '0;
        isr_clr     = '0;

        for (int i = 0; i < NUM_IRQ; i++) begin
            irr_d[i] = trig_q[i] ? sync2_q[i] : (irr_q[i] | rise[i]);
        end

        if (wr_en) begin
            unique case (wr_addr)
                2'd0: mask_d = wr_data[NUM_IRQ-1:0];
                2'd1: trig_d = wr_data[NUM_IRQ-1:0];
                2'd2: begin
                    base_d = wr_data[VEC_W-1:0];
                    rot_d  = wr_data[16];
                    aeoi_d = wr_data[17];
                end
                2'd3: begin
                    if (wr_data[8]) begin
                        if (eoi_id_ok) isr_clr[eoi_id] = 1'b1;
                    end else if (isr_any) begin
                        isr_clr[isr_top_id] = 1'b1;
                        last_d              = isr_top_id;
                    end
                end
                default: ;
            endcase
        end

        if (ack1) begin
            state_d = StAck2;
            if (win_ok) begin
                id_d            = win_id;
                spur_d          = 1'b0;
                isr_set[win_id] = 1'b1;
                // A fresh edge arriving on the same cycle stays pending.
                if (!trig_q[win_id]) irr_d[win_id] = rise[win_id];
            end else begin
                id_d   = LastId;
                spur_d = 1'b1;
            end
        end else if (ack2) begin
            state_d     = StIdle;
            vec_d       = base_q + VEC_W'(id_q);
            vec_valid_d = 1'b1;
            if (aeoi_q && !spur_q) begin
                isr_clr[id_q] = 1'b1;
                last_d        = id_q;
            end
        end

        // Clear before set so an acknowledge beats a same-cycle EOI on that bit.
        isr_d = (isr_q & ~isr_clr) | isr_set;
        int_d = (state_q == StIdle) && !inta && win_ok;

        if (rd_en) begin
            unique case (rd_addr)
                2'd0: rd_data_d = 32'(irr_q);
                2'd1: rd_data_d = 32'(isr_q);
                2'd2: rd_data_d = 32'(mask_q);
                2'd3: rd_data_d = {14'b0, aeoi_q, rot_q, 16'(base_q)};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            irr_q       <= '0;
            isr_q       <= '0;
            mask_q      <= '1;
            trig_q      <= '0;
            base_q      <= '0;
            rot_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            last_q      <= LastId;
            state_q     <= StIdle;
            id_q        <= '0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            mask_q      <= mask_d;
            trig_q      <= trig_d;
            base_q      <= base_d;
            rot_q       <= rot_d;
            aeoi_q      <= aeoi_d;
            last_q      <= last_d;
            state_q     <= state_d;
            id_q        <= id_d;
            spur_q      <= spur_d;
            int_q       <= int_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign int_o     = int_q;
    assign vec_o     = vec_q;
    assign vec_valid = vec_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_pic_core_n.sv
// Self-checking bench for pic_core_n: directed scenarios plus randomized two-request
// rounds, all checked against a rank-based behavioural model of the controller.
module tb_pic_core_n;

    localparam int N  = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_lines = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_addr = '0;
    logic [31:0]   rd_data;
    logic          inta = 1'b0;
    logic          int_o;
    logic [VW-1:0] vec_o;
    logic          vec_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state; m_pend mirrors IRR.
    logic [N-1:0]  m_mask, m_trig, m_isr, m_pend;
    logic [VW-1:0] m_base;
    bit            m_rot, m_aeoi;
    int            m_last;

    pic_core_n #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_lines(irq_lines),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .inta     (inta),
        .int_o    (int_o),
        .vec_o    (vec_o),
        .vec_valid(vec_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_mask = '1; m_trig = '0; m_isr = '0; m_pend = '0;
        m_base = '0; m_rot = 0; m_aeoi = 0; m_last = N - 1;
    endfunction

    function automatic int m_start();
        return m_rot ? (m_last + 1) % N : 0;
    endfunction

    function automatic int m_top(input logic [N-1:0] v);
        int s;
        s = m_start();
        for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic int m_rank(input int id);
        return (id - m_start() + N) % N;
    endfunction

    function automatic bit m_req();
        int p, i;
        p = m_top(m_pend & ~m_mask);
        i = m_top(m_isr);
        if (p < 0) return 0;
        return (i < 0) || (m_rank(p) < m_rank(i));
    endfunction

    function automatic logic [VW-1:0] m_ack();
        int id;
        bit spur;
        spur = !m_req();
        if (!spur) begin
            id = m_top(m_pend & ~m_mask);
            m_isr[id] = 1'b1;
            if (!m_trig[id]) m_pend[id] = 1'b0;
        end else begin
            id = N - 1;
        end
        if (m_aeoi && !spur) begin
            m_isr[id] = 1'b0;
            m_last = id;
        end
        return m_base + VW'(id);
    endfunction

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        int t;
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
        case (addr)
            2'd0: m_mask = data[N-1:0];
            2'd1: m_trig = data[N-1:0];
            2'd2: begin m_base = data[VW-1:0]; m_rot = data[16]; m_aeoi = data[17]; end
            default: begin
                if (data[8]) begin
                    m_isr[data[3:0]] = 1'b0;
                end else begin
                    t = m_top(m_isr);
                    if (t >= 0) begin m_isr[t] = 1'b0; m_last = t; end
                end
            end
        endcase
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        rd_en = 1'b1; rd_addr = addr;
        tick();
        rd_en = 1'b0;
        data = rd_data;
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        irq_lines = irq_lines | bits;
        m_pend = m_pend | bits;
        tick();
        tick();
        irq_lines = irq_lines & ~bits;
    endtask

    task automatic wait_int(output bit seen);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (int_o) begin seen = 1; break; end
            tick();
        end
    endtask

    task automatic do_ack(output logic [VW-1:0] v, output logic vv, output logic vv_after,
                          output logic int1);
        inta = 1'b1; tick(); int1 = int_o;
        inta = 1'b0; tick();
        inta = 1'b1; tick(); v = vec_o; vv = vec_valid;
        inta = 1'b0; tick(); vv_after = vec_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({int_o, vec_valid, vec_o, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got int=%0b vv=%0b vec=%h rd=%h, want all 0",
                     int_o, vec_valid, vec_o, rd_data);
        end
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'(m_mask)) begin
            n_fail++; $display("FAIL reset_mask: got %h want %h", d, 32'(m_mask));
        end
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_isr: got %h want 0", d); end
    endtask

    task automatic test_fixed_vectoring();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h20);
        irq_lines[3] = 1'b1; m_pend[3] = 1'b1;
        tick(); tick();
        irq_lines[3] = 1'b0;
        tick();
        n_checks++;
        if (int_o !== 1'b0) begin n_fail++; $display("FAIL fix_int_early: got %b want 0", int_o); end
        tick();
        n_checks++;
        if (int_o !== m_req()) begin
            n_fail++; $display("FAIL fix_int_latency: got %b want %b", int_o, m_req());
        end
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        n_checks++;
        if ({v, vv, vva, i1} !== {ev, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fix_vector: got vec=%h vv=%b vv_next=%b int=%b want vec=%h 1 0 0",
                     v, vv, vva, i1, ev);
        end
        n_checks++;
        if (vec_o !== ev) begin n_fail++; $display("FAIL fix_vec_hold: got %h want %h", vec_o, ev); end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'(m_isr)) begin n_fail++; $display("FAIL fix_isr: got %h want %h", d, 32'(m_isr)); end
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'(m_pend)) begin
            n_fail++; $display("FAIL fix_irr: got %h want %h", d, 32'(m_pend));
        end
        wr(2'd3, 32'h0);
    endtask

    task automatic test_nesting();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        bit seen;
        pulse(N'(1) << 5);
        wait_int(seen);
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        irq_lines[7] = 1'b1; m_pend[7] = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (int_o !== m_req()) begin
            n_fail++; $display("FAIL nest_blocked: got %b want %b", int_o, m_req());
        end
        irq_lines[2] = 1'b1; m_pend[2] = 1'b1;
        wait_int(seen);
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL nest_preempt: int_o got 0 want 1"); end
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        n_checks++;
        if (v !== ev) begin n_fail++; $display("FAIL nest_vec: got %h want %h", v, ev); end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'(m_isr)) begin n_fail++; $display("FAIL nest_isr: got %h want %h", d, 32'(m_isr)); end
        wr(2'd3, 32'h0);
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'(m_isr)) begin n_fail++; $display("FAIL nest_eoi: got %h want %h", d, 32'(m_isr)); end
        repeat (3) tick();
        n_checks++;
        if (int_o !== m_req()) begin n_fail++; $display("FAIL nest_still_blocked: got %b want %b", int_o, m_req()); end
        wr(2'd3, 32'h0);
        wait_int(seen);
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        n_checks++;
        if (v !== ev) begin n_fail++; $display("FAIL nest_vec7: got %h want %h", v, ev); end
        wr(2'd3, 32'h0);
        irq_lines[2] = 1'b0; irq_lines[7] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_rotating_aeoi();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        bit seen;
        wr(2'd1, 32'h3);
        wr(2'd2, 32'h30000 | 32'(m_base));
        irq_lines[1:0] = 2'b11; m_pend[1:0] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_int(seen);
            do_ack(v, vv, vva, i1);
            ev = m_ack();
            n_checks++;
            if ({seen, v, vv} !== {1'b1, ev, 1'b1}) begin
                n_fail++;
                $display("FAIL rot_vec%0d: got int=%b vec=%h vv=%b want 1 %h 1", k, seen, v, vv, ev);
            end
            rd(2'd1, d);
            n_checks++;
            if (d !== 32'(m_isr)) begin
                n_fail++; $display("FAIL rot_isr%0d: got %h want %h", k, d, 32'(m_isr));
            end
        end
        irq_lines[1:0] = 2'b00; m_pend[1:0] = 2'b00;
        repeat (6) tick();
        wr(2'd1, 32'h0);
        wr(2'd2, 32'(m_base));
        n_checks++;
        if (int_o !== m_req()) begin n_fail++; $display("FAIL rot_idle: got %b want %b", int_o, m_req()); end
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        bit seen;
        wr(2'd1, 32'h10);
        irq_lines[4] = 1'b1; m_pend[4] = 1'b1;
        wait_int(seen);
        irq_lines[4] = 1'b0; m_pend[4] = 1'b0;
        repeat (5) tick();
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        n_checks++;
        if ({seen, v, vv} !== {1'b1, ev, 1'b1}) begin
            n_fail++; $display("FAIL spur_vec: got int=%b vec=%h vv=%b want 1 %h 1", seen, v, vv, ev);
        end
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'(m_isr)) begin n_fail++; $display("FAIL spur_isr: got %h want %h", d, 32'(m_isr)); end
        wr(2'd1, 32'h0);
    endtask

    task automatic test_mask_specific_eoi();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        wr(2'd0, 32'h8);
        pulse(N'(1) << 3);
        repeat (6) tick();
        n_checks++;
        if (int_o !== m_req()) begin n_fail++; $display("FAIL mask_blocks: got %b want %b", int_o, m_req()); end
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'(m_pend)) begin n_fail++; $display("FAIL mask_irr: got %h want %h", d, 32'(m_pend)); end
        wr(2'd0, 32'h0);
        n_checks++;
        if (int_o !== 1'b0) begin n_fail++; $display("FAIL unmask_early: got %b want 0", int_o); end
        tick();
        n_checks++;
        if (int_o !== m_req()) begin n_fail++; $display("FAIL unmask_int: got %b want %b", int_o, m_req()); end
        do_ack(v, vv, vva, i1);
        ev = m_ack();
        n_checks++;
        if (v !== ev) begin n_fail++; $display("FAIL mask_vec: got %h want %h", v, ev); end
        wr(2'd3, 32'h103);
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'(m_isr)) begin n_fail++; $display("FAIL spec_eoi: got %h want %h", d, 32'(m_isr)); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [VW-1:0] v, ev;
        logic vv, vva, i1;
        bit seen;
        int a, b, id;
        for (int it = 0; it < 20; it++) begin
            wr(2'd2, ($urandom_range(0, 1) << 16) | $urandom_range(0, 255));
            a = $urandom_range(0, N - 1);
            b = $urandom_range(0, N - 1);
            pulse((N'(1) << a) | (N'(1) << b));
            for (int r = 0; r < 2 && m_pend != '0; r++) begin
                wait_int(seen);
                id = m_top(m_pend & ~m_mask);
                do_ack(v, vv, vva, i1);
                ev = m_ack();
                n_checks++;
                if ({seen, v, vv, vva} !== {1'b1, ev, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_vec it%0d: got int=%b vec=%h vv=%b%b want 1 %h 10",
                             it, seen, v, vv, vva, ev);
                end
                if ($urandom_range(0, 1) == 1) wr(2'd3, 32'h100 | 32'(id));
                else wr(2'd3, 32'h0);
                rd(2'd1, d);
                n_checks++;
                if (d !== 32'(m_isr)) begin
                    n_fail++; $display("FAIL rand_isr it%0d: got %h want %h", it, d, 32'(m_isr));
                end
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [31:0] d;
        bit seen;
        wr(2'd2, 32'h55);
        rd(2'd3, d);
        pulse(N'(1) << 6);
        wait_int(seen);
        inta = 1'b1; tick(); inta = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({int_o, vec_valid, vec_o, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got int=%0b vv=%0b vec=%h rd=%h, want all 0",
                     int_o, vec_valid, vec_o, rd_data);
        end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'(m_mask)) begin n_fail++; $display("FAIL rst_mid_mask: got %h want %h", d, 32'(m_mask)); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++;
        if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_inta: vec_valid got 1 want 0"); end
        tick();
        n_checks++;
        if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_inta2: vec_valid got 1 want 0"); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fixed_vectoring();
        test_nesting();
        test_rotating_aeoi();
        test_spurious();
        test_mask_specific_eoi();
        test_random();
        test_reset_mid_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
